// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encodings, default timing values and counter sizing helper
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZING = 2'd3
  } alarm_state_t;

  localparam int DEF_HOLD_CYCLES    = 2_500_000;
  localparam int DEF_REPEAT_CYCLES  = 500_000;
  localparam int DEF_BEEP_CYCLES    = 2_500_000;
  localparam int DEF_SNOOZE_MINUTES = 9;
  localparam int DEF_RING_MINUTES   = 5;

  // Bits needed to count 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_repeat.sv
// rtl/button_repeat.sv - button edge detect with hold delay and auto-repeat pulses
module button_repeat
  import alarm_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn,
  output logic pulse
);

  localparam int CW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  logic          btn_q;
  logic          active;
  logic          repeating;
  logic [CW-1:0] cnt;

  // A press only counts once its rising edge is seen while enabled; release or disable clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= 1'b0;
      active    <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
      pulse     <= 1'b0;
    end else begin
      btn_q <= btn;
      pulse <= 1'b0;
      if (!en || !btn) begin
        active    <= 1'b0;
        repeating <= 1'b0;
        cnt       <= '0;
      end else if (!btn_q) begin
        pulse     <= 1'b1;
        active    <= 1'b1;
        repeating <= 1'b0;
        cnt       <= '0;
      end else if (active && !repeating) begin
        if (cnt == HOLD_LAST) begin
          pulse     <= 1'b1;
          repeating <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (active) begin
        if (cnt == REPEAT_LAST) begin
          pulse <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm setting buttons, match trigger, ring/snooze FSM and buzzer gating
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
  parameter int BEEP_CYCLES    = DEF_BEEP_CYCLES,
  parameter int SNOOZE_MINUTES = DEF_SNOOZE_MINUTES,
  parameter int RING_MINUTES   = DEF_RING_MINUTES
) (
  input  logic        i_Clk_5MHz,
  input  logic        i_Reset_n,
  input  logic        i_Set_Mode,
  input  logic        i_Btn_Hours,
  input  logic        i_Btn_Minutes,
  input  logic        i_Alarm_En,
  input  logic        i_Snooze,
  input  logic        i_Stop,
  input  logic [15:0] i_Current_Time,
  input  logic        i_Current_PM,
  input  logic [15:0] i_Alarm_Time,
  input  logic        i_Alarm_PM,
  output logic        o_Hours_Inc,
  output logic        o_Minutes_Inc,
  output logic        o_Buzzer,
  output logic [1:0]  o_State
);

  localparam int RW = cnt_width(RING_MINUTES + 1);
  localparam int SW = cnt_width(SNOOZE_MINUTES + 1);
  localparam int BW = cnt_width(BEEP_CYCLES);
  localparam logic [RW-1:0] RING_LOAD   = RW'(RING_MINUTES);
  localparam logic [RW-1:0] RING_ONE    = RW'(1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_MINUTES);
  localparam logic [SW-1:0] SNOOZE_ONE  = SW'(1);
  localparam logic [BW-1:0] BEEP_LAST   = BW'(BEEP_CYCLES - 1);

  alarm_state_t  state_q, state_d;
  logic [RW-1:0] ring_cnt, ring_d;
  logic [SW-1:0] snz_cnt, snz_d;
  logic [BW-1:0] beep_cnt;
  logic          beep_on;
  logic          match, match_q, trigger;
  logic [3:0]    min_q;
  logic          tick;
  logic          min_lock_q;
  logic          min_btn_eff;
  logic          hr_pulse, min_pulse;

  // Minutes stay locked out from the moment hours joins until the minutes button is let go
  assign min_btn_eff = i_Btn_Minutes & ~i_Btn_Hours & ~min_lock_q;

  button_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_hours_btn (
    .clk  (i_Clk_5MHz),
    .rst_n(i_Reset_n),
    .en   (i_Set_Mode),
    .btn  (i_Btn_Hours),
    .pulse(hr_pulse)
  );

  button_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_minutes_btn (
    .clk  (i_Clk_5MHz),
    .rst_n(i_Reset_n),
    .en   (i_Set_Mode),
    .btn  (min_btn_eff),
    .pulse(min_pulse)
  );

  // Gating with the live mode level keeps a leftover registered pulse from escaping after setting ends
  assign o_Hours_Inc   = hr_pulse & i_Set_Mode;
  assign o_Minutes_Inc = min_pulse & i_Set_Mode;

  assign match   = (i_Current_Time == i_Alarm_Time) && (i_Current_PM == i_Alarm_PM);
  assign trigger = match & ~match_q;
  assign tick    = (i_Current_Time[3:0] != min_q);

  // match_q resets high so equal times at reset release never look like a fresh match
  always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      match_q    <= 1'b1;
      min_q      <= 4'd0;
      min_lock_q <= 1'b0;
    end else begin
      match_q    <= match;
      min_q      <= i_Current_Time[3:0];
      min_lock_q <= i_Btn_Minutes & (min_lock_q | i_Btn_Hours);
    end
  end

  // State and minute counters
  always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= ST_DISARMED;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      ring_cnt <= ring_d;
      snz_cnt  <= snz_d;
    end
  end

  // Next state: enable dominates, then set mode / stop, then snooze, then minute timeouts
  always_comb begin
    state_d = state_q;
    ring_d  = ring_cnt;
    snz_d   = snz_cnt;
    if (!i_Alarm_En) begin
      state_d = ST_DISARMED;
      ring_d  = '0;
      snz_d   = '0;
    end else begin
      case (state_q)
        ST_DISARMED: state_d = ST_ARMED;
        ST_ARMED: begin
          if (trigger && !i_Set_Mode) begin
            state_d = ST_RINGING;
            ring_d  = RING_LOAD;
          end
        end
        ST_RINGING: begin
          if (i_Set_Mode || i_Stop) begin
            state_d = ST_ARMED;
            ring_d  = '0;
          end else if (i_Snooze) begin
            state_d = ST_SNOOZING;
            ring_d  = '0;
            snz_d   = SNOOZE_LOAD;
          end else if (tick) begin
            if (ring_cnt <= RING_ONE) begin
              state_d = ST_ARMED;
              ring_d  = '0;
            end else begin
              ring_d = ring_cnt - RING_ONE;
            end
          end
        end
        ST_SNOOZING: begin
          if (i_Set_Mode || i_Stop) begin
            state_d = ST_ARMED;
            snz_d   = '0;
          end else if (tick) begin
            if (snz_cnt <= SNOOZE_ONE) begin
              state_d = ST_RINGING;
              ring_d  = RING_LOAD;
              snz_d   = '0;
            end else begin
              snz_d = snz_cnt - SNOOZE_ONE;
            end
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

  // Beep cadence restarts in the "on" half every time ringing is entered
  always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      beep_cnt <= '0;
      beep_on  <= 1'b0;
    end else if (state_q != ST_RINGING) begin
      beep_cnt <= '0;
      beep_on  <= 1'b1;
    end else if (beep_cnt == BEEP_LAST) begin
      beep_cnt <= '0;
      beep_on  <= ~beep_on;
    end else begin
      beep_cnt <= beep_cnt + 1'b1;
    end
  end

  assign o_Buzzer = (state_q == ST_RINGING) & beep_on;
  assign o_State  = state_q;

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: Alarm_Controller

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2_500_000, button hold time before auto-repeat starts (0.5 s at 5 MHz).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 500_000, auto-repeat pulse period (0.1 s).
REQ-003 SHALL have parameter BEEP_CYCLES, default 2_500_000, buzzer on/off half-period.
REQ-004 SHALL have parameter SNOOZE_MINUTES, default 9, snooze length in minute ticks.
REQ-005 SHALL have parameter RING_MINUTES, default 5, ringing timeout in minute ticks.
REQ-006 SHALL have one clock and one asynchronous, active-low reset; ports listed below.
REQ-007 i_Clk_5MHz  in  1  system clock, all logic on rising edge.
REQ-008 i_Reset_n  in  1  asynchronous active-low reset.
REQ-009 i_Set_Mode  in  1  level; 1 = alarm-setting mode.
REQ-010 i_Btn_Hours, i_Btn_Minutes  in  1 each  debounced, synchronous button levels.
REQ-011 i_Alarm_En  in  1  level; alarm enable switch.
REQ-012 i_Snooze, i_Stop  in  1 each  one-cycle synchronous request pulses.
REQ-013 i_Current_Time  in  16  BCD HH:MM (4 digits), 12-hour; i_Current_PM  in  1.
REQ-014 i_Alarm_Time  in  16  BCD HH:MM from Alarm_Time; i_Alarm_PM  in  1.
REQ-015 o_Hours_Inc, o_Minutes_Inc  out  1 each  one-cycle increment pulses to Alarm_Time.
REQ-016 o_Buzzer  out  1  gated beep enable; o_State  out  2  current FSM state.

Function
REQ-017 Button path: only while i_Set_Mode=1; rising edge of a button SHALL give one Inc pulse on the next cycle.
REQ-018 Button held HOLD_CYCLES after the edge SHALL then give one pulse every REPEAT_CYCLES until released; release clears the counter immediately.
REQ-019 Both buttons high: hours path SHALL be served, minutes pulses suppressed until i_Btn_Minutes is released and pressed again.
REQ-020 o_Hours_Inc and o_Minutes_Inc SHALL never be high in the same cycle, and SHALL stay 0 while i_Set_Mode=0.
REQ-021 Match = (i_Current_Time==i_Alarm_Time) && (i_Current_PM==i_Alarm_PM); trigger = rising edge of match (registered match_q).
REQ-022 Minute tick = one-cycle pulse when i_Current_Time[3:0] differs from its registered copy.
REQ-023 FSM states: DISARMED=0, ARMED=1, RINGING=2, SNOOZING=3, driven on o_State.
REQ-024 Any state with i_Alarm_En=0 SHALL go to DISARMED next cycle (highest priority).
REQ-025 DISARMED -> ARMED when i_Alarm_En=1.
REQ-026 ARMED -> RINGING on trigger with i_Set_Mode=0; ring counter loads RING_MINUTES.
REQ-027 RINGING: i_Stop -> ARMED; else i_Snooze -> SNOOZING with snooze counter = SNOOZE_MINUTES; else ring counter reaching 0 on a tick -> ARMED.
REQ-028 SNOOZING: each tick decrements; reaching 0 -> RINGING with ring counter reloaded; i_Stop -> ARMED; triggers ignored.
REQ-029 i_Stop and i_Snooze in the same cycle: Stop SHALL win.
REQ-030 i_Set_Mode=1 in RINGING or SNOOZING SHALL go to ARMED; triggers ignored while i_Set_Mode=1.
REQ-031 o_Buzzer SHALL be high only in RINGING: on BEEP_CYCLES, off BEEP_CYCLES, starting on, beep counter cleared on RINGING entry.
REQ-032 Counters SHALL be sized by $clog2 of their parameter; no wrap beyond terminal counts.

Reset
REQ-033 Reset asserted: state DISARMED, all outputs 0, all counters 0, match_q=1 and minute copy = 0 (no trigger if times equal at release).
REQ-034 Reset mid-ring SHALL silence o_Buzzer asynchronously; outputs SHALL be stable on first clock after deassertion.

Structure
REQ-035 Package Alarm_Pkg SHALL hold state encodings and default parameter values.
REQ-036 Sub-module Button_Repeat (edge detect + hold/repeat counter), instantiated twice.

Verification (HOLD_CYCLES=4, REPEAT_CYCLES=2, BEEP_CYCLES=3, SNOOZE_MINUTES=2, RING_MINUTES=3)
REQ-037 Set_Mode=1, hold Btn_Minutes 10 cycles -> pulses at cycle 1, then 5,7,9,11 relative to edge; none after release.
REQ-038 Both buttons held -> only o_Hours_Inc pulses; Set_Mode=0 -> zero pulses.
REQ-039 En=1, alarm 07:30 AM, current steps 07:29 -> 07:30 AM -> o_State=2 next cycle, o_Buzzer 1,1,1,0,0,0 repeating.
REQ-040 Ringing, Snooze pulse -> State=3; 2 minute ticks -> State=2; Stop+Snooze same cycle -> State=1.
REQ-041 Ringing untouched for 3 ticks -> State=1, Buzzer 0; times still equal -> no re-trigger.
REQ-042 Reset released while times equal -> remains DISARMED/ARMED, never RINGING; reset mid-ring -> Buzzer 0 immediately.
